// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg
//   Shared constants for the multiplier arbiter slice: FSM state encoding,
//   state width, default parameter values and a small index-width helper.
//   No ports (package).

package mult_arb_pkg;

    localparam int DEF_NUM_REQ        = 2;
    localparam int DEF_WIDTH          = 32;
    localparam int DEF_TIMEOUT_CYCLES = 40;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_ISSUE = 2'd1;
    localparam logic [STATE_W-1:0] ST_WAIT  = 2'd2;
    localparam logic [STATE_W-1:0] ST_RESP  = 2'd3;

    // Width of an index that can address n requesters (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_arb_rr.sv
// mult_arb_rr
//   Combinational round-robin picker. Scans requesters starting one past the
//   last-served index (ptr) and wrapping, returning the first one that is set.
// Ports
//   req        in   NUM_REQ  request vector
//   ptr        in   IDX_W    index of the requester served most recently
//   any_req    out  1        at least one request is set
//   win_onehot out  NUM_REQ  one-hot winner (all zero when no request)
//   win_idx    out  IDX_W    binary index of the winner

module mult_arb_rr #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any_req,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0]   win_idx
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // Checking ptr+NUM_REQ last means the previous winner has the lowest
    // priority, which is what bounds waiting to NUM_REQ-1 operations.
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        cand       = '0;
        found      = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found            = 1'b1;
                win_idx          = cand;
                win_onehot[cand] = 1'b1;
            end
        end
        any_req = found;
    end

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter
//   Shares one sequential unsigned multiplier (multu) among NUM_REQ clients.
//   Round-robin pick, operand latch, single doMult pulse, wait for mult_done,
//   then a one-cycle response to the winning client.
//   Optional macro MULT_ARB_TIMEOUT_EN adds a WAIT-state watchdog that ends
//   the operation with result=0 and err=1 after TIMEOUT_CYCLES WAIT cycles.
// Ports
//   clk        in   1              system clock, rising edge
//   reset      in   1              asynchronous, active-high
//   req        in   NUM_REQ        per-client request, held until grant
//   req_a      in   NUM_REQ*WIDTH  operand A, client i at [i*WIDTH +: WIDTH]
//   req_b      in   NUM_REQ*WIDTH  operand B, same packing
//   grant      out  NUM_REQ        one-hot pulse: operands accepted
//   resp_valid out  NUM_REQ        one-hot pulse: result valid for client i
//   result     out  WIDTH          product, valid while resp_valid is set
//   err        out  1              timeout flag, pulses with resp_valid
//   mult_a     out  WIDTH          to multu.a, stable ISSUE..WAIT
//   mult_b     out  WIDTH          to multu.b
//   mult_do    out  1              to multu.doMult, one-cycle pulse
//   mult_out   in   WIDTH          from multu.out
//   mult_done  in   1              from multu.mult_done

module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int WIDTH          = DEF_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic [WIDTH-1:0]           result,
    output logic                       err,
    output logic [WIDTH-1:0]           mult_a,
    output logic [WIDTH-1:0]           mult_b,
    output logic                       mult_do,
    input  logic [WIDTH-1:0]           mult_out,
    input  logic                       mult_done
);

    localparam int IDX_W = idx_width(NUM_REQ);

    logic [STATE_W-1:0] state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [NUM_REQ-1:0] owner_oh;
    logic               wait_armed;
    logic               timed_out;

    logic               any_req;
    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0]   win_idx;

    mult_arb_rr #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req        (req),
        .ptr        (ptr),
        .any_req    (any_req),
        .win_onehot (win_onehot),
        .win_idx    (win_idx)
    );

    // doMult is a pure decode of ISSUE so it is exactly one cycle wide and
    // drops immediately with the asynchronous reset.
    assign mult_do = (state == ST_ISSUE);

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Counts WAIT cycles from WAIT entry; a real done in the same cycle as
    // the limit wins over the timeout.
    assign timed_out = (state == ST_WAIT) && !(wait_armed && mult_done) &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= timed_out;
            if (state == ST_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign timed_out = 1'b0;
    assign err       = 1'b0;
`endif

    // Main FSM. mult_done is ignored in the first WAIT cycle because multu
    // may still be showing the done flag of the previous operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            ptr        <= IDX_W'(NUM_REQ - 1);
            owner      <= '0;
            owner_oh   <= '0;
            grant      <= '0;
            resp_valid <= '0;
            result     <= '0;
            mult_a     <= '0;
            mult_b     <= '0;
            wait_armed <= 1'b0;
        end else begin
            grant      <= '0;
            resp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        mult_a   <= req_a[win_idx*WIDTH +: WIDTH];
                        mult_b   <= req_b[win_idx*WIDTH +: WIDTH];
                        owner    <= win_idx;
                        owner_oh <= win_onehot;
                        grant    <= win_onehot;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_armed <= 1'b0;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    wait_armed <= 1'b1;
                    if (wait_armed && mult_done) begin
                        result     <= mult_out;
                        resp_valid <= owner_oh;
                        state      <= ST_RESP;
                    end else if (timed_out) begin
                        result     <= '0;
                        resp_valid <= owner_oh;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    ptr   <= owner;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter
//   Self-checking bench for mult_arbiter. A behavioural multu stand-in
//   answers doMult after a random latency and keeps its done flag high
//   (stale) into the next operation's first WAIT cycle. A transaction-level
//   model predicts grant, doMult, operands, response and result each cycle;
//   directed tasks pin the model with hand-computed products.

module tb_mult_arbiter;

    localparam int NUM_REQ        = 2;
    localparam int WIDTH          = 32;
    localparam int TIMEOUT_CYCLES = 40;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [WIDTH-1:0]         result;
    logic                     err;
    logic [WIDTH-1:0]         mult_a;
    logic [WIDTH-1:0]         mult_b;
    logic                     mult_do;
    logic [WIDTH-1:0]         mult_out;
    logic                     mult_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mult_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .WIDTH          (WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_a      (req_a),
        .req_b      (req_b),
        .grant      (grant),
        .resp_valid (resp_valid),
        .result     (result),
        .err        (err),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_do    (mult_do),
        .mult_out   (mult_out),
        .mult_done  (mult_done)
    );

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // ---------------- multu stand-in ----------------
    bit               mu_stuck = 1'b0;
    bit               mu_busy  = 1'b0;
    bit               mu_hold  = 1'b0;
    int               mu_cnt   = 0;
    logic [WIDTH-1:0] mu_prod  = '0;

    always @(negedge clk) begin
        if (reset) begin
            mu_busy   = 1'b0;
            mu_hold   = 1'b0;
            mult_done = 1'b0;
            mult_out  = '0;
        end else if (mult_do) begin
            mu_prod = mult_a * mult_b;
            mu_cnt  = $urandom_range(6, 1);
            mu_busy = 1'b1;
            mu_hold = 1'b1;
        end else if (mu_hold) begin
            mu_hold = 1'b0;
        end else if (mu_busy) begin
            mult_done = 1'b0;
            if (!mu_stuck) begin
                mu_cnt--;
                if (mu_cnt <= 0) begin
                    mult_done = 1'b1;
                    mult_out  = mu_prod;
                    mu_busy   = 1'b0;
                end
            end
        end
    end

    // ---------------- transaction-level model ----------------
    // phase: 0 idle, 1 grant/doMult cycle, 2 waiting for product, 3 response
    int               m_phase = 0;
    int               m_k     = 0;
    int               m_owner = 0;
    int               m_last  = NUM_REQ - 1;
    bit               m_err   = 1'b0;
    logic [WIDTH-1:0] m_a, m_b, m_prod;

    // Winner is the requester at the smallest forward distance after the
    // last-served one.
    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
        int best  = -1;
        int bestd = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r[i]) begin
                int d = (i - last - 1 + 2 * NUM_REQ) % NUM_REQ;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    always begin
        @(posedge clk);
        #1;
        if (reset) begin
            check_output("rst_grant", grant, 0);
            check_output("rst_resp", resp_valid, 0);
            check_output("rst_mult_do", mult_do, 0);
            check_output("rst_err", err, 0);
        end else begin
            check_output("grant", grant,
                         (m_phase == 1) ? (64'd1 << m_owner) : 64'd0);
            check_output("mult_do", mult_do, (m_phase == 1) ? 1 : 0);
            check_output("resp_valid", resp_valid,
                         (m_phase == 3) ? (64'd1 << m_owner) : 64'd0);
            check_output("err", err, (m_phase == 3) ? m_err : 1'b0);
            if (m_phase == 3) check_output("result", result, m_prod);
            if (m_phase == 1 || m_phase == 2) begin
                check_output("mult_a", mult_a, m_a);
                check_output("mult_b", mult_b, m_b);
            end
        end
        @(negedge clk);
        #1;
        if (reset) begin
            m_phase = 0;
            m_last  = NUM_REQ - 1;
            m_err   = 1'b0;
        end else begin
            case (m_phase)
                0: if (|req) begin
                    m_owner = rr_pick(req, m_last);
                    m_a     = req_a[m_owner*WIDTH +: WIDTH];
                    m_b     = req_b[m_owner*WIDTH +: WIDTH];
                    m_prod  = m_a * m_b;
                    m_err   = 1'b0;
                    m_phase = 1;
                end
                1: begin
                    m_phase = 2;
                    m_k     = 1;
                end
                2: begin
                    if (m_k >= 2 && mult_done) begin
                        m_phase = 3;
`ifdef MULT_ARB_TIMEOUT_EN
                    end else if (m_k == TIMEOUT_CYCLES) begin
                        m_phase = 3;
                        m_prod  = '0;
                        m_err   = 1'b1;
`endif
                    end
                    m_k++;
                end
                default: begin
                    m_last  = m_owner;
                    m_phase = 0;
                end
            endcase
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic apply_stimulus(input int i, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b,
                                  input logic [WIDTH-1:0] exp_result);
        int  n_do    = 0;
        bit  granted = 1'b0;
        bit  seen    = 1'b0;
        @(negedge clk);
        req[i]                 = 1'b1;
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (mult_do) n_do++;
            if (grant[i]) begin
                granted = 1'b1;
                req[i]  = 1'b0;
            end
            if (resp_valid[i]) begin
                seen = 1'b1;
                check_output("op_result", result, exp_result);
                check_output("op_other_resp", resp_valid & ~(2'b1 << i), 0);
            end
        end
        check_output("op_granted", granted, 1);
        check_output("op_resp_seen", seen, 1);
        check_output("op_mult_do_count", n_do, 1);
    endtask

    task automatic run_pair();
        int n_resp = 0;
        @(negedge clk);
        req   = 2'b11;
        req_a = {32'h3, 32'h2};
        req_b = {32'h69, 32'h5};
        for (int c = 0; c < 100 && n_resp < 2; c++) begin
            @(negedge clk);
            for (int j = 0; j < NUM_REQ; j++) if (grant[j]) req[j] = 1'b0;
            if (|resp_valid) begin
                if (n_resp == 0) begin
                    check_output("pair_first_idx", resp_valid, 2'b01);
                    check_output("pair_first_res", result, 32'hA);
                end else begin
                    check_output("pair_second_idx", resp_valid, 2'b10);
                    check_output("pair_second_res", result, 32'h13B);
                end
                n_resp++;
            end
        end
        check_output("pair_resp_count", n_resp, 2);
    endtask

    task automatic reset_mid_wait();
        bit granted = 1'b0;
        int n_resp  = 0;
        @(negedge clk);
        req[0]      = 1'b1;
        req_a[31:0] = 32'd7;
        req_b[31:0] = 32'd9;
        for (int c = 0; c < 20 && !granted; c++) begin
            @(negedge clk);
            if (grant[0]) begin
                granted = 1'b1;
                req[0]  = 1'b0;
            end
        end
        check_output("rmw_granted", granted, 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check_output("rmw_mult_a", mult_a, 0);
        check_output("rmw_mult_b", mult_b, 0);
        check_output("rmw_result", result, 0);
        check_output("rmw_mult_do", mult_do, 0);
        check_output("rmw_resp", resp_valid, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (|resp_valid) n_resp++;
        end
        check_output("rmw_no_resp", n_resp, 0);
        apply_stimulus(0, 32'd7, 32'd9, 32'd63);
    endtask

`ifdef MULT_ARB_TIMEOUT_EN
    task automatic run_timeout();
        int  g    = -1;
        bit  seen = 1'b0;
        mu_stuck = 1'b1;
        @(negedge clk);
        req[0]      = 1'b1;
        req_a[31:0] = 32'd3;
        req_b[31:0] = 32'd4;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (grant[0]) begin
                g      = c;
                req[0] = 1'b0;
            end
            if (resp_valid[0]) begin
                seen = 1'b1;
                check_output("to_err", err, 1);
                check_output("to_result", result, 0);
                check_output("to_latency", c - g, TIMEOUT_CYCLES + 1);
            end
        end
        check_output("to_resp_seen", seen, 1);
        mu_stuck = 1'b0;
    endtask
`endif

    function automatic logic [WIDTH-1:0] rand_op();
        case ($urandom_range(5, 0))
            0:       return '0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic random_phase(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] && grant[i]) begin
                    if ($urandom_range(3, 0) != 0) req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(3, 0) == 0) begin
                        req[i]                  = 1'b1;
                        req_a[i*WIDTH +: WIDTH] = rand_op();
                        req_b[i*WIDTH +: WIDTH] = rand_op();
                    end
                end else if ($urandom_range(19, 0) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        @(negedge clk);
        req = '0;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_a     = '0;
        req_b     = '0;
        mult_done = 1'b0;
        mult_out  = '0;
        repeat (3) @(negedge clk);
        check_output("reset_mult_a", mult_a, 0);
        check_output("reset_result", result, 0);
        reset = 1'b0;

        apply_stimulus(0, 32'd2, 32'd5, 32'h0000_000A);
        apply_stimulus(1, 32'h3, 32'h69, 32'h0000_013B);
        apply_reset();
        run_pair();
        apply_stimulus(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        apply_stimulus(0, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'h0000_0010);
        reset_mid_wait();
`ifdef MULT_ARB_TIMEOUT_EN
        run_timeout();
`endif
        random_phase(3000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
